// File: rtl/int_mul_lane.sv
// int_mul_lane: pipelined RV32M multiply lane (MUL/MULH/MULHSU/MULHU).
// A 2-entry input buffer feeds three pipeline stages: operand extension (M1),
// registered partial products (M2), and final sum/select into the CDB
// output registers (M3). Stages collapse bubbles and stall on a missing grant.
module int_mul_lane #(
  parameter int DATA_LEN  = 32,
  parameter int ROBID_LEN = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mul_v,
  input  logic [DATA_LEN-1:0]  mul_src1,
  input  logic [DATA_LEN-1:0]  mul_src2,
  input  logic [ROBID_LEN-1:0] mul_robid,
  input  logic [2:0]           mul_func3,
  input  logic                 cdb_gnt,
  output logic                 cdb_req,
  output logic [DATA_LEN-1:0]  cdb_data,
  output logic [ROBID_LEN-1:0] cdb_robid,
  output logic                 fu_free,
  output logic                 fu_free_1c,
  output logic                 ovf_err
);

  localparam int OPW = DATA_LEN + 1;          // extended operand width
  localparam int LO  = DATA_LEN / 2;          // low slice of operand A
  localparam int AHW = OPW - LO;              // high (signed) slice of A
  localparam int PPW = OPW + AHW;             // partial product width
  localparam int PW  = 2 * DATA_LEN;          // product bits actually consumed
  localparam int EW  = ROBID_LEN + 3 + 2 * DATA_LEN;

  // Extend an operand to OPW bits; illegal encodings zero it so the product is 0.
  function automatic logic signed [OPW-1:0] ext_operand(input logic [DATA_LEN-1:0] v,
                                                        input logic sgn,
                                                        input logic kill);
    if (kill) return '0;
    return {sgn & v[DATA_LEN-1], v};
  endfunction

  // Pick the low word for MUL, the high word for the MULH variants.
  function automatic logic [DATA_LEN-1:0] sel_result(input logic signed [PW-1:0] p,
                                                     input logic hi);
    return hi ? p[PW-1:DATA_LEN] : p[DATA_LEN-1:0];
  endfunction

  logic [EW-1:0]           r_ib_q [2];
  logic [1:0]              r_ib_occ;
  logic                    r_v_p1, r_v_p2;
  logic signed [OPW-1:0]   r_a_p1, r_b_p1;
  logic [ROBID_LEN-1:0]    r_robid_p1, r_robid_p2;
  logic                    r_hi_p1, r_hi_p2;
  logic signed [PPW-1:0]   r_pp_hi_p2, r_pp_lo_p2;

  logic                    w_m1_en, w_m2_en, w_m3_en;
  logic                    w_pop, w_push, w_drop, w_full, w_wr_idx;
  logic [1:0]              w_eff;
  logic [EW-1:0]           w_head;
  logic [ROBID_LEN-1:0]    w_hd_robid;
  logic [2:0]              w_hd_f3;
  logic [DATA_LEN-1:0]     w_hd_src1, w_hd_src2;
  logic                    w_s1_sgn, w_s2_sgn;
  logic signed [PPW-1:0]   w_a_hi_x, w_a_lo_x, w_b_x, w_pp_hi, w_pp_lo;
  logic signed [PW-1:0]    w_hi_ext, w_lo_ext, w_prod;

  // Bubble-collapsing load enables; cdb_req is the M3 valid bit.
  assign w_m3_en = ~cdb_req | cdb_gnt;
  assign w_m2_en = ~r_v_p2 | w_m3_en;
  assign w_m1_en = ~r_v_p1 | w_m2_en;

  assign w_full   = (r_ib_occ == 2'd2);
  assign w_pop    = w_m1_en & (r_ib_occ != 2'd0);
  assign w_push   = mul_v & (~w_full | w_pop);
  assign w_drop   = mul_v & w_full & ~w_pop;
  assign w_wr_idx = w_full | ((r_ib_occ == 2'd1) & ~w_pop);

  assign w_eff      = r_ib_occ + {1'b0, mul_v};
  assign fu_free    = (w_eff == 2'd0);
  assign fu_free_1c = (w_eff == 2'd1);

  assign w_head     = r_ib_q[0];
  assign w_hd_robid = w_head[EW-1 -: ROBID_LEN];
  assign w_hd_f3    = w_head[2*DATA_LEN +: 3];
  assign w_hd_src1  = w_head[DATA_LEN +: DATA_LEN];
  assign w_hd_src2  = w_head[0 +: DATA_LEN];
  assign w_s1_sgn   = (w_hd_f3[1:0] == 2'b01) | (w_hd_f3[1:0] == 2'b10);
  assign w_s2_sgn   = (w_hd_f3[1:0] == 2'b01);

  // Split A into a signed high slice and an unsigned low slice; B stays whole.
  assign w_a_hi_x = {{(PPW-AHW){r_a_p1[OPW-1]}}, r_a_p1[OPW-1:LO]};
  assign w_a_lo_x = {{(PPW-LO){1'b0}}, r_a_p1[LO-1:0]};
  assign w_b_x    = {{(PPW-OPW){r_b_p1[OPW-1]}}, r_b_p1};
  assign w_pp_hi  = w_a_hi_x * w_b_x;
  assign w_pp_lo  = w_a_lo_x * w_b_x;

  // Only the low 2*DATA_LEN bits of the full signed product are ever selected.
  assign w_hi_ext = {{(PW-PPW){r_pp_hi_p2[PPW-1]}}, r_pp_hi_p2};
  assign w_lo_ext = {{(PW-PPW){r_pp_lo_p2[PPW-1]}}, r_pp_lo_p2};
  assign w_prod   = (w_hi_ext <<< LO) + w_lo_ext;

  // Control state: buffer occupancy, stage valids, sticky overflow, CDB outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ib_occ  <= 2'd0;
      r_v_p1    <= 1'b0;
      r_v_p2    <= 1'b0;
      cdb_req   <= 1'b0;
      cdb_data  <= '0;
      cdb_robid <= '0;
      ovf_err   <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_ib_occ <= r_ib_occ + 2'd1;
        2'b01:   r_ib_occ <= r_ib_occ - 2'd1;
        default: r_ib_occ <= r_ib_occ;
      endcase
      if (w_drop) ovf_err <= 1'b1;
      if (w_m1_en) r_v_p1 <= (r_ib_occ != 2'd0);
      if (w_m2_en) r_v_p2 <= r_v_p1;
      if (w_m3_en) begin
        cdb_req <= r_v_p2;
        if (r_v_p2) begin
          cdb_data  <= sel_result(w_prod, r_hi_p2);
          cdb_robid <= r_robid_p2;
        end
      end
    end
  end

  // Datapath registers: input buffer shift/write, M1 operands, M2 partial products.
  always_ff @(posedge clk) begin
    if (w_pop) r_ib_q[0] <= r_ib_q[1];
    if (w_push) r_ib_q[w_wr_idx] <= {mul_robid, mul_func3, mul_src1, mul_src2};
    // ---- M1: operand extension ----
    if (w_pop) begin
      r_a_p1     <= ext_operand(w_hd_src1, w_s1_sgn, w_hd_f3[2]);
      r_b_p1     <= ext_operand(w_hd_src2, w_s2_sgn, w_hd_f3[2]);
      r_robid_p1 <= w_hd_robid;
      r_hi_p1    <= (w_hd_f3[1:0] != 2'b00) & ~w_hd_f3[2];
    end
    // ---- M2: partial products ----
    if (w_m2_en & r_v_p1) begin
      r_pp_hi_p2 <= w_pp_hi;
      r_pp_lo_p2 <= w_pp_lo;
      r_robid_p2 <= r_robid_p1;
      r_hi_p2    <= r_hi_p1;
    end
  end

endmodule

// File: tb/tb_int_mul_lane.sv
// Directed testbench for int_mul_lane.
module tb_int_mul_lane;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mul_v = 1'b0;
  logic [31:0] mul_src1 = '0;
  logic [31:0] mul_src2 = '0;
  logic [5:0]  mul_robid = '0;
  logic [2:0]  mul_func3 = '0;
  logic        cdb_gnt = 1'b0;
  logic        cdb_req;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_robid;
  logic        fu_free, fu_free_1c, ovf_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int_mul_lane #(.DATA_LEN(32), .ROBID_LEN(6)) dut (
    .clk(clk), .rst(rst), .mul_v(mul_v), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_robid(mul_robid), .mul_func3(mul_func3), .cdb_gnt(cdb_gnt),
    .cdb_req(cdb_req), .cdb_data(cdb_data), .cdb_robid(cdb_robid),
    .fu_free(fu_free), .fu_free_1c(fu_free_1c), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] rob);
    mul_v = v; mul_func3 = f3; mul_src1 = a; mul_src2 = b; mul_robid = rob;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 6'd0);
    cyc(); cyc();
    @(negedge clk);
    chk_cnt++; if (cdb_req !== 1'b0) $display("FAIL rst_req got %b exp 0", cdb_req); else pass_cnt++;
    chk_cnt++; if (cdb_data !== 32'd0) $display("FAIL rst_data got %h exp 0", cdb_data); else pass_cnt++;
    chk_cnt++; if (cdb_robid !== 6'd0) $display("FAIL rst_robid got %0d exp 0", cdb_robid); else pass_cnt++;
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b10) $display("FAIL rst_flags got %b exp 10", {fu_free, fu_free_1c}); else pass_cnt++;
    chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL rst_ovf got %b exp 0", ovf_err); else pass_cnt++;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if ({cdb_req, fu_free, fu_free_1c, ovf_err} !== 4'b0100) $display("FAIL rst_release got %b exp 0100", {cdb_req, fu_free, fu_free_1c, ovf_err}); else pass_cnt++;
  endtask

  task automatic test_mulhu_latency();
    cdb_gnt = 1'b1;
    cyc();
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5);
    @(negedge clk);
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b01) $display("FAIL lat_flags got %b exp 01", {fu_free, fu_free_1c}); else pass_cnt++;
    cyc();
    mul_v = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_cnt++; if (cdb_req !== 1'b0) $display("FAIL lat_early_req t+%0d got %b exp 0", i, cdb_req); else pass_cnt++;
      cyc();
    end
    @(negedge clk);
    chk_cnt++; if (cdb_req !== 1'b1) $display("FAIL lat_req t+4 got %b exp 1", cdb_req); else pass_cnt++;
    chk_cnt++; if (cdb_data !== 32'hFFFF_FFFE) $display("FAIL lat_data got %h exp fffffffe", cdb_data); else pass_cnt++;
    chk_cnt++; if (cdb_robid !== 6'd5) $display("FAIL lat_robid got %0d exp 5", cdb_robid); else pass_cnt++;
    cyc();
    @(negedge clk);
    chk_cnt++; if (cdb_req !== 1'b0) $display("FAIL lat_after_gnt got %b exp 0", cdb_req); else pass_cnt++;
  endtask

  task automatic test_sign();
    logic [2:0]  tf3 [12] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001,
                              3'b001, 3'b011, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [31:0] ta  [12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'd7,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                              32'h8000_0000, 32'd3, 32'h7FFF_FFFF, 32'd2};
    logic [31:0] tb  [12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'd6,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd2,
                              32'h8000_0000, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te  [12] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_002A,
                              32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001,
                              32'hC000_0000, 32'h0000_0000, 32'h3FFF_FFFF, 32'h0000_0001};
    int n;
    cdb_gnt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      drive(1'b1, tf3[i], ta[i], tb[i], 6'(i + 8));
      cyc();
      mul_v = 1'b0;
      n = 0;
      @(negedge clk);
      while (!cdb_req && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk_cnt++; if (cdb_req !== 1'b1) $display("FAIL sign_req[%0d] got %b exp 1 (timeout)", i, cdb_req); else pass_cnt++;
      chk_cnt++; if (cdb_data !== te[i]) $display("FAIL sign_data[%0d] f3=%b got %h exp %h", i, tf3[i], cdb_data, te[i]); else pass_cnt++;
      chk_cnt++; if (cdb_robid !== 6'(i + 8)) $display("FAIL sign_robid[%0d] got %0d exp %0d", i, cdb_robid, i + 8); else pass_cnt++;
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic       exp_req;
    logic [5:0] exp_rob;
    for (int k = 0; k < 16; k++) begin
      cyc();
      drive(k < 4, 3'b000, 32'(k + 1), 32'd100, 6'(k + 1));
      cdb_gnt = (k >= 10);
      @(negedge clk);
      exp_req = (k >= 4) && (k <= 13);
      exp_rob = (k <= 10) ? 6'd1 : 6'(k - 9);
      chk_cnt++; if (cdb_req !== exp_req) $display("FAIL b2b_req c%0d got %b exp %b", k, cdb_req, exp_req); else pass_cnt++;
      if (exp_req) begin
        chk_cnt++; if (cdb_robid !== exp_rob) $display("FAIL b2b_robid c%0d got %0d exp %0d", k, cdb_robid, exp_rob); else pass_cnt++;
        chk_cnt++; if (cdb_data !== 32'(exp_rob) * 32'd100) $display("FAIL b2b_data c%0d got %0d exp %0d", k, cdb_data, 32'(exp_rob) * 32'd100); else pass_cnt++;
      end
    end
    chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", ovf_err); else pass_cnt++;
  endtask

  // Fill M1..M3 with three instructions while the CDB withholds grant.
  task automatic prefill(input logic [5:0] base);
    cdb_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      drive(1'b1, 3'b000, 32'(base) + 32'(k), 32'd3, base + 6'(k));
    end
    cyc();
    mul_v = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_flags();
    prefill(6'd10);
    @(negedge clk);
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b10) $display("FAIL flag_s0 got %b exp 10", {fu_free, fu_free_1c}); else pass_cnt++;
    cyc();
    drive(1'b1, 3'b000, 32'd13, 32'd3, 6'd13);
    @(negedge clk);
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b01) $display("FAIL flag_s1 got %b exp 01", {fu_free, fu_free_1c}); else pass_cnt++;
    cyc();
    drive(1'b1, 3'b000, 32'd14, 32'd3, 6'd14);
    @(negedge clk);
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b00) $display("FAIL flag_s2 got %b exp 00", {fu_free, fu_free_1c}); else pass_cnt++;
    cyc();
    mul_v = 1'b0;
    @(negedge clk);
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b00) $display("FAIL flag_s3 got %b exp 00", {fu_free, fu_free_1c}); else pass_cnt++;
    chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL flag_ovf got %b exp 0", ovf_err); else pass_cnt++;
    cyc();
    cdb_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++; if (cdb_req !== 1'b1 || cdb_robid !== 6'(10 + i)) $display("FAIL flag_drain[%0d] got req=%b rob=%0d exp req=1 rob=%0d", i, cdb_req, cdb_robid, 10 + i); else pass_cnt++;
      chk_cnt++; if (cdb_data !== 32'(30 + 3 * i)) $display("FAIL flag_data[%0d] got %0d exp %0d", i, cdb_data, 30 + 3 * i); else pass_cnt++;
      cyc();
    end
    @(negedge clk);
    chk_cnt++; if (cdb_req !== 1'b0) $display("FAIL flag_extra_req got %b exp 0", cdb_req); else pass_cnt++;
  endtask

  task automatic test_overflow();
    prefill(6'd20);
    for (int k = 0; k < 3; k++) begin
      cyc();
      drive(1'b1, 3'b000, 32'(23 + k), 32'd3, 6'(23 + k));
    end
    @(negedge clk);
    chk_cnt++; if ({fu_free, fu_free_1c, ovf_err} !== 3'b000) $display("FAIL ovf_pre got %b exp 000", {fu_free, fu_free_1c, ovf_err}); else pass_cnt++;
    cyc();
    mul_v = 1'b0;
    @(negedge clk);
    chk_cnt++; if (ovf_err !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf_err); else pass_cnt++;
    cyc();
    cdb_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++; if (cdb_req !== 1'b1 || cdb_robid !== 6'(20 + i)) $display("FAIL ovf_drain[%0d] got req=%b rob=%0d exp req=1 rob=%0d", i, cdb_req, cdb_robid, 20 + i); else pass_cnt++;
      cyc();
    end
    @(negedge clk);
    chk_cnt++; if (cdb_req !== 1'b0) $display("FAIL ovf_dropped_req got %b exp 0", cdb_req); else pass_cnt++;
    repeat (3) cyc();
    @(negedge clk);
    chk_cnt++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf_err); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    cdb_gnt = 1'b1;
    cyc();
    drive(1'b1, 3'b000, 32'd30, 32'd2, 6'd30);
    cyc();
    drive(1'b1, 3'b000, 32'd31, 32'd2, 6'd31);
    cyc();
    mul_v = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_cnt++; if (cdb_req !== 1'b0) $display("FAIL mid_req got %b exp 0", cdb_req); else pass_cnt++;
    chk_cnt++; if (cdb_data !== 32'd0) $display("FAIL mid_data got %h exp 0", cdb_data); else pass_cnt++;
    chk_cnt++; if (cdb_robid !== 6'd0) $display("FAIL mid_robid got %0d exp 0", cdb_robid); else pass_cnt++;
    chk_cnt++; if ({fu_free, fu_free_1c} !== 2'b10) $display("FAIL mid_flags got %b exp 10", {fu_free, fu_free_1c}); else pass_cnt++;
    chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL mid_ovf got %b exp 0", ovf_err); else pass_cnt++;
    cyc(); cyc();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cdb_req) seen++;
      cyc();
    end
    chk_cnt++; if (seen != 0) $display("FAIL mid_post_req got %0d requests exp 0", seen); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mulhu_latency();
    test_sign();
    test_back_to_back();
    test_flags();
    test_overflow();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
